spdif_frame_enc: RTL and testbench



---
 rtl/spdif_frame_enc.sv | 155 +++++++++++++++
 tb/tb_spdif_frame_enc.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spdif_frame_enc.sv
`default_nettype none
// ============================================================================
// Module   : spdif_frame_enc
// Purpose  : S/PDIF (IEC 60958) sub-frame encoder, biphase-mark coded, one
//            cell per clk128 cycle. Optional macro SPDIF_UNDERRUN_INVALID_EN
//            makes underrun substitute sub-frames carry V = 1.
// Revision : 1.0 - initial release
// ============================================================================
module spdif_frame_enc (
   input  logic        clk128,
   input  logic        reset,
   input  logic        i_valid,
   output logic        i_ready,
   input  logic        i_is_left,
   input  logic [23:0] i_audio,
   input  logic        i_user,
   input  logic        i_control,
   output logic [7:0]  next_sub_frame_number,
   output logic        spdif
);

   localparam logic [7:0] c_pre_b      = 8'b11101000;
   localparam logic [7:0] c_pre_m      = 8'b11100010;
   localparam logic [7:0] c_pre_w      = 8'b11100100;
   localparam logic [7:0] c_last_frame = 8'd191;
   localparam logic [5:0] c_last_cell  = 6'd63;
`ifdef SPDIF_UNDERRUN_INVALID_EN
   localparam logic       c_sub_v      = 1'b1;
`else
   localparam logic       c_sub_v      = 1'b0;
`endif

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t      r_state;
   logic [5:0]  r_cnt;
   logic [8:0]  r_pre;
   logic [27:0] r_data;
   logic        r_prev_left;
   logic [7:0]  r_fnum;
   logic        r_spdif;
   logic        r_hold_full;
   logic        r_hold_left;
   logic        r_hold_user;
   logic        r_hold_ctrl;
   logic [23:0] r_hold_audio;

   logic        w_xfer;
   logic        w_boundary;
   logic        w_load;
   logic        w_ld_left;
   logic        w_ld_user;
   logic        w_ld_ctrl;
   logic        w_ld_v;
   logic [23:0] w_ld_audio;
   logic [7:0]  w_ld_pre;
   logic [27:0] w_ld_data;

   assign i_ready               = !r_hold_full;
   assign w_xfer                = i_valid && !r_hold_full;
   assign w_boundary            = (r_state == ST_RUN) && (r_cnt == c_last_cell);
   assign next_sub_frame_number = r_fnum;
   assign spdif                 = r_spdif;

   // Source of the next sub-frame: hold register, bypassed input, or substitute.
   always_comb begin
      w_load     = 1'b0;
      w_ld_left  = i_is_left;
      w_ld_user  = i_user;
      w_ld_ctrl  = i_control;
      w_ld_audio = i_audio;
      w_ld_v     = 1'b0;
      if (r_state == ST_IDLE) begin
         w_load = w_xfer;
      end else if (w_boundary) begin
         w_load = 1'b1;
         if (r_hold_full) begin
            w_ld_left  = r_hold_left;
            w_ld_user  = r_hold_user;
            w_ld_ctrl  = r_hold_ctrl;
            w_ld_audio = r_hold_audio;
         end else if (!i_valid) begin
            w_ld_left  = !r_prev_left;
            w_ld_user  = 1'b0;
            w_ld_ctrl  = 1'b0;
            w_ld_audio = 24'd0;
            w_ld_v     = c_sub_v;
         end
      end
      if (!w_ld_left)
         w_ld_pre = c_pre_w;
      else if (r_fnum == 8'd0)
         w_ld_pre = c_pre_b;
      else
         w_ld_pre = c_pre_m;
      w_ld_data = {^{w_ld_ctrl, w_ld_user, w_ld_v, w_ld_audio},
                   w_ld_ctrl, w_ld_user, w_ld_v, w_ld_audio};
   end

   always_ff @(posedge clk128) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_cnt        <= 6'd0;
         r_pre        <= 9'd0;
         r_data       <= 28'd0;
         r_prev_left  <= 1'b0;
         r_fnum       <= 8'd0;
         r_spdif      <= 1'b0;
         r_hold_full  <= 1'b0;
         r_hold_left  <= 1'b0;
         r_hold_user  <= 1'b0;
         r_hold_ctrl  <= 1'b0;
         r_hold_audio <= 24'd0;
      end else begin
         if (w_boundary) begin
            r_hold_full <= 1'b0;
         end else if ((r_state == ST_RUN) && w_xfer) begin
            r_hold_full  <= 1'b1;
            r_hold_left  <= i_is_left;
            r_hold_user  <= i_user;
            r_hold_ctrl  <= i_control;
            r_hold_audio <= i_audio;
         end

         if (r_state == ST_RUN) begin
            // Preamble cells follow the pattern's own edges relative to the prior level.
            if (r_cnt[5:3] == 3'd0) begin
               r_spdif <= r_spdif ^ r_pre[8] ^ r_pre[7];
               r_pre   <= r_pre << 1;
            end else if (!r_cnt[0]) begin
               r_spdif <= !r_spdif;
            end else begin
               r_spdif <= r_spdif ^ r_data[0];
               r_data  <= r_data >> 1;
            end
            r_cnt <= r_cnt + 6'd1;
         end

         if (w_load) begin
            r_state     <= ST_RUN;
            r_cnt       <= 6'd0;
            r_pre       <= {1'b0, w_ld_pre};
            r_data      <= w_ld_data;
            r_prev_left <= w_ld_left;
            if (!w_ld_left)
               r_fnum <= (r_fnum == c_last_frame) ? 8'd0 : r_fnum + 8'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spdif_frame_enc.sv
`default_nettype none
// Testbench for spdif_frame_enc: cell-level reference model, line decoder,
// directed table of sub-frames, mid-frame reset and randomized long run.
module tb_spdif_frame_enc;

   logic        clk128 = 1'b0;
   logic        reset;
   logic        i_valid;
   logic        i_ready;
   logic        i_is_left;
   logic [23:0] i_audio;
   logic        i_user;
   logic        i_control;
   logic [7:0]  next_sub_frame_number;
   logic        spdif;

   always #5 clk128 = ~clk128;

   spdif_frame_enc dut (
      .clk128                (clk128),
      .reset                 (reset),
      .i_valid               (i_valid),
      .i_ready               (i_ready),
      .i_is_left             (i_is_left),
      .i_audio               (i_audio),
      .i_user                (i_user),
      .i_control             (i_control),
      .next_sub_frame_number (next_sub_frame_number),
      .spdif                 (spdif)
   );

   localparam bit [7:0] c_pre_b = 8'b11101000;
   localparam bit [7:0] c_pre_m = 8'b11100010;
   localparam bit [7:0] c_pre_w = 8'b11100100;
`ifdef SPDIF_UNDERRUN_INVALID_EN
   localparam bit c_sub_v = 1'b1;
`else
   localparam bit c_sub_v = 1'b0;
`endif

   typedef struct packed {
      bit        left;
      bit [23:0] audio;
      bit        user;
      bit        ctrl;
   } word_t;

   typedef struct {
      word_t    w;
      bit [7:0] exp_pre;
      bit       exp_p;
      bit [7:0] exp_fnum;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model state: one expected 64-cell sub-frame at a time.
   bit          m_run;
   int          m_k;
   bit [63:0]   m_cells;
   bit          m_spdif;
   bit [7:0]    m_fnum;
   bit          m_prev_left;
   word_t       m_hold[$];
   bit          m_last_xfer;
   int          wrap_idx = -1;

   logic [63:0] cap;
   logic        cap_prior;
   logic [7:0]  cap_fnum;
   logic        prev_line = 1'b0;
   int          n_frames = 0;
   bit          frame_done;

   function automatic bit [63:0] encode(word_t w, bit v, bit prior, bit [7:0] fnum);
      bit [31:0] slots;
      bit [7:0]  pat;
      bit [63:0] c;
      bit        lvl;
      slots = '0;
      for (int i = 0; i < 24; i++) slots[4+i] = w.audio[i];
      slots[28] = v;
      slots[29] = w.user;
      slots[30] = w.ctrl;
      slots[31] = ^slots[30:4];
      pat = !w.left ? c_pre_w : ((fnum == 8'd0) ? c_pre_b : c_pre_m);
      c = '0;
      for (int k = 0; k < 8; k++) c[k] = pat[7-k] ^ prior;
      lvl = c[7];
      for (int s = 4; s < 32; s++) begin
         lvl = ~lvl;
         c[2*s] = lvl;
         if (slots[s]) lvl = ~lvl;
         c[2*s+1] = lvl;
      end
      return c;
   endfunction

   task automatic m_load(input word_t w, input bit v);
      m_cells     = encode(w, v, m_spdif, m_fnum);
      m_prev_left = w.left;
      if (!w.left) begin
         if (m_fnum == 8'd191) begin
            m_fnum   = 8'd0;
            wrap_idx = n_frames + 1;
         end else begin
            m_fnum = m_fnum + 8'd1;
         end
      end
   endtask

   task automatic cycle(input bit rst, input bit vld, input word_t w);
      bit    xfer;
      int    em;
      word_t sub;
      em = -1;
      reset = rst; i_valid = vld; i_is_left = w.left;
      i_audio = w.audio; i_user = w.user; i_control = w.ctrl;
      @(posedge clk128);
      xfer = vld && (m_hold.size() == 0);
      frame_done = 1'b0;
      if (rst) begin
         m_run = 0; m_k = 0; m_spdif = 0; m_fnum = 0; m_prev_left = 0;
         m_hold.delete();
         xfer = 0;
      end else if (!m_run) begin
         if (xfer) begin
            m_load(w, 1'b0);
            m_run = 1;
            m_k   = 0;
         end
      end else begin
         m_spdif = m_cells[m_k];
         em = m_k;
         if (m_k == 63) begin
            if (m_hold.size() != 0) begin
               m_load(m_hold.pop_front(), 1'b0);
            end else if (xfer) begin
               m_load(w, 1'b0);
            end else begin
               sub = '0;
               sub.left = !m_prev_left;
               m_load(sub, c_sub_v);
            end
            m_k = 0;
         end else begin
            if (xfer) m_hold.push_back(w);
            m_k++;
         end
      end
      m_last_xfer = xfer;
      #1;
      check("spdif", spdif, m_spdif);
      check("i_ready", i_ready, m_hold.size() == 0);
      check("frame_num", next_sub_frame_number, m_fnum);
      if (em >= 0) begin
         if (em == 0) begin
            cap_prior = prev_line;
            cap_fnum  = next_sub_frame_number;
         end
         cap[em] = spdif;
         if (em == 63) begin
            frame_done = 1'b1;
            n_frames++;
         end
      end
      prev_line = spdif;
   endtask

   // Receiver-style decode of the captured line cells.
   task automatic decode(output logic [7:0] pre, output logic [31:0] slots, output bit bmc_ok);
      bmc_ok = 1'b1;
      slots  = '0;
      for (int k = 0; k < 8; k++) pre[7-k] = cap[k] ^ cap_prior;
      for (int s = 4; s < 32; s++) begin
         if (cap[2*s] === cap[2*s-1]) bmc_ok = 1'b0;
         slots[s] = cap[2*s] ^ cap[2*s+1];
      end
   endtask

   function automatic vec_t mk(bit l, bit [23:0] a, bit u, bit c, bit [7:0] pre, bit p, bit [7:0] fn);
      vec_t v;
      v.w.left = l; v.w.audio = a; v.w.user = u; v.w.ctrl = c;
      v.exp_pre = pre; v.exp_p = p; v.exp_fnum = fn;
      return v;
   endfunction

   initial begin
      vec_t        tbl[6];
      word_t       idle_w;
      word_t       w;
      logic [7:0]  pre;
      logic [31:0] slots;
      bit          bmc_ok;
      bit          feed_left;
      int          fed, dec, budget, quiet, b_checked, target;

      tbl[0] = mk(1, 24'hFFFFF8, 1, 1, c_pre_b, 1, 8'd0);
      tbl[1] = mk(0, 24'h123456, 0, 0, c_pre_w, 1, 8'd1);
      tbl[2] = mk(1, 24'h987655, 0, 0, c_pre_m, 0, 8'd1);
      tbl[3] = mk(0, 24'h000000, 1, 0, c_pre_w, 1, 8'd2);
      tbl[4] = mk(1, 24'h800001, 0, 1, c_pre_m, 1, 8'd2);
      tbl[5] = mk(0, 24'hFFFFFF, 1, 1, c_pre_w, 0, 8'd3);
      idle_w = '0;

      repeat (3) cycle(1'b1, 1'b0, idle_w);
      cycle(1'b0, 1'b0, idle_w);
      check("reset_spdif", spdif, 1'b0);
      check("reset_ready", i_ready, 1'b1);
      check("reset_fnum", next_sub_frame_number, 8'd0);

      // Table-driven sub-frames, then one underrun substitute.
      fed = 0; dec = 0; budget = 0;
      while (dec < 7 && budget < 1000) begin
         cycle(1'b0, fed < 6, (fed < 6) ? tbl[fed].w : idle_w);
         if (m_last_xfer) fed++;
         if (frame_done) begin
            decode(pre, slots, bmc_ok);
            check("tbl_bmc", bmc_ok, 1'b1);
            check("tbl_even_parity", ^slots[31:4], 1'b0);
            if (dec < 6) begin
               check("tbl_preamble", pre, tbl[dec].exp_pre);
               check("tbl_audio", slots[27:4], tbl[dec].w.audio);
               check("tbl_v", slots[28], 1'b0);
               check("tbl_u", slots[29], tbl[dec].w.user);
               check("tbl_c", slots[30], tbl[dec].w.ctrl);
               check("tbl_p", slots[31], tbl[dec].exp_p);
               check("tbl_fnum", cap_fnum, tbl[dec].exp_fnum);
            end else begin
               check("sub_preamble", pre, c_pre_m);
               check("sub_audio", slots[27:4], 24'd0);
               check("sub_v", slots[28], c_sub_v);
               check("sub_uc", slots[30:29], 2'b00);
               check("sub_fnum", cap_fnum, 8'd3);
            end
            dec++;
         end
         budget++;
      end
      check("tbl_frames_seen", dec, 7);

      // Reset at cell 30 of a right sub-frame.
      repeat (2) cycle(1'b1, 1'b0, idle_w);
      w = tbl[1].w;
      cycle(1'b0, 1'b1, w);
      budget = 0;
      while (m_k != 30 && budget < 100) begin
         cycle(1'b0, 1'b0, idle_w);
         budget++;
      end
      check("mid_fnum_before", next_sub_frame_number, 8'd1);
      cycle(1'b1, 1'b0, idle_w);
      check("mid_spdif", spdif, 1'b0);
      check("mid_ready", i_ready, 1'b1);
      check("mid_fnum", next_sub_frame_number, 8'd0);
      quiet = 0;
      repeat (70) begin
         cycle(1'b0, 1'b0, idle_w);
         if (spdif !== 1'b0) quiet++;
      end
      check("mid_idle_quiet", quiet, 0);

      // Long randomized run with occasional underruns; must wrap the block.
      repeat (2) cycle(1'b1, 1'b0, idle_w);
      feed_left = 1'b1; b_checked = 0; budget = 0;
      target = n_frames + 400;
      wrap_idx = -1;
      while ((n_frames < target || b_checked == 0) && budget < 64 * 700) begin
         w.left  = feed_left;
         w.audio = 24'($urandom);
         w.user  = 1'($urandom);
         w.ctrl  = 1'($urandom);
         cycle(1'b0, $urandom_range(0, 15) != 0, w);
         if (m_last_xfer) feed_left = ~feed_left;
         if (frame_done) begin
            decode(pre, slots, bmc_ok);
            check("rnd_bmc", bmc_ok, 1'b1);
            check("rnd_even_parity", ^slots[31:4], 1'b0);
            if (wrap_idx >= 0 && (n_frames - 1) > wrap_idx && pre !== c_pre_w) begin
               check("wrap_preamble_b", pre, c_pre_b);
               wrap_idx = -1;
               b_checked++;
            end
         end
         budget++;
      end
      check("wrap_checked", b_checked > 0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
